// File: rtl/ram.sv
// PDP-8/e main memory: 12-bit words, 15-bit extended address, only the low
// IMPL_WORDS locations exist. Synchronous write, registered read-first read.
module ram #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 15,
    parameter int IMPL_WORDS = 8192
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:DATA_WIDTH-1] din,
    input  logic                  write_en,
    input  logic [0:ADDR_WIDTH-1] addr,
    output logic [0:DATA_WIDTH-1] dout
);

    localparam int IDX_W = (IMPL_WORDS > 1) ? $clog2(IMPL_WORDS) : 1;

    logic [DATA_WIDTH-1:0] mem [IMPL_WORDS];

    // PDP-8 numbering puts the MSB at bit 0; copying into a descending
    // vector keeps the numeric value and gives conventional low-bit indexing.
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] wdata;
    logic [IDX_W-1:0]      idx;
    logic                  impl;

    assign a     = addr;
    assign wdata = din;
    assign idx   = a[IDX_W-1:0];
    assign impl  = {{(32-ADDR_WIDTH){1'b0}}, a} < 32'(IMPL_WORDS);

    // Array has no reset: contents survive reset, only the strobe is gated.
    always_ff @(posedge clk) begin
        if (reset && write_en && impl)
            mem[idx] <= wdata;
    end

    // Read-first: the array read sees the pre-write contents at this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            dout <= '0;
        else if (impl)
            dout <= mem[idx];
        else
            dout <= '0;
    end

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: table of write/read vectors plus hand-written
// sequences for read-first collision, hold, and asynchronous reset.
module tb_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] din;
    logic        write_en;
    logic [14:0] addr;
    logic [11:0] dout;

    int checks = 0;
    int errors = 0;

    ram dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .write_en (write_en),
        .addr     (addr),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [14:0] a;
        logic [11:0] d;
        logic        chk;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [14:0] a, logic [11:0] d,
                                logic chk, logic [11:0] exp, string name);
        vec_t v;
        v.we = we; v.a = a; v.d = d; v.chk = chk; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: dout=%o expected=%o", name, act, exp);
        end
    endtask

    // Apply inputs away from the edge, clock once, sample 1 time unit later.
    task automatic cycle(logic we, logic [14:0] a, logic [11:0] d);
        write_en = we;
        addr     = a;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        write_en = 1'b0;
        addr     = '0;
        din      = '0;
        #2;
        check("reset_state", dout, 12'o0000);
        @(posedge clk);
        #1;
        check("reset_hold", dout, 12'o0000);

        @(negedge clk);
        reset = 1'b1;

        vecs.push_back(mk(1, 15'o00000, 12'o7777, 0, 12'o0000, "wr_00000"));
        vecs.push_back(mk(1, 15'o10000, 12'o5252, 0, 12'o0000, "wr_10000"));
        vecs.push_back(mk(1, 15'o17777, 12'o2525, 0, 12'o0000, "wr_17777"));
        vecs.push_back(mk(0, 15'o00000, 12'o0000, 1, 12'o7777, "rd_00000"));
        vecs.push_back(mk(0, 15'o10000, 12'o0000, 1, 12'o5252, "rd_10000"));
        vecs.push_back(mk(0, 15'o17777, 12'o0000, 1, 12'o2525, "rd_17777"));
        // read-modify-write: din = 2525 + 1, old value seen at the write edge
        vecs.push_back(mk(1, 15'o17777, 12'o2526, 1, 12'o2525, "rmw_edge"));
        vecs.push_back(mk(0, 15'o17777, 12'o0000, 1, 12'o2526, "rmw_after"));
        // same-address collision is read-first
        vecs.push_back(mk(1, 15'o00000, 12'o1234, 1, 12'o7777, "coll_old"));
        vecs.push_back(mk(0, 15'o00000, 12'o0000, 1, 12'o1234, "coll_new"));
        // unimplemented range: writes dropped, reads zero, no aliasing
        vecs.push_back(mk(1, 15'o20000, 12'o5252, 1, 12'o0000, "unimpl_wr"));
        vecs.push_back(mk(0, 15'o20000, 12'o0000, 1, 12'o0000, "unimpl_rd"));
        vecs.push_back(mk(0, 15'o00000, 12'o0000, 1, 12'o1234, "no_alias_0"));
        vecs.push_back(mk(1, 15'o37777, 12'o4444, 1, 12'o0000, "unimpl_37777"));
        vecs.push_back(mk(0, 15'o17777, 12'o0000, 1, 12'o2526, "no_alias_17777"));
        vecs.push_back(mk(0, 15'o77777, 12'o0000, 1, 12'o0000, "unimpl_77777"));
        vecs.push_back(mk(0, 15'o10000, 12'o0000, 1, 12'o5252, "rd_10000_b"));

        foreach (vecs[i]) begin
            cycle(vecs[i].we, vecs[i].a, vecs[i].d);
            if (vecs[i].chk)
                check(vecs[i].name, dout, vecs[i].exp);
        end

        // hold: idle reads of 10000 for 20 cycles
        for (int i = 0; i < 20; i++) begin
            cycle(0, 15'o10000, 12'o7070);
            check("hold_10000", dout, 12'o5252);
        end
        cycle(0, 15'o00000, 12'o0000);
        check("hold_then_00000", dout, 12'o1234);
        cycle(0, 15'o17777, 12'o0000);
        check("hold_then_17777", dout, 12'o2526);

        // mid-cycle async reset with dout nonzero
        cycle(0, 15'o10000, 12'o0000);
        check("pre_reset", dout, 12'o5252);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", dout, 12'o0000);
        // write attempted under reset must be suppressed
        cycle(1, 15'o10000, 12'o1111);
        check("reset_wr_blocked", dout, 12'o0000);
        cycle(1, 15'o00000, 12'o1111);
        check("reset_held", dout, 12'o0000);
        @(negedge clk);
        reset = 1'b1;
        cycle(0, 15'o10000, 12'o0000);
        check("post_reset_10000", dout, 12'o5252);
        cycle(0, 15'o00000, 12'o0000);
        check("post_reset_00000", dout, 12'o1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
